// File: rtl/remote_comm.sv
// remote_comm: host-side command transmitter / response receiver for the
// Knight robot UART link. A 16-bit command is sent as two back-to-back 8N1
// frames (high byte first); every received byte is presented on resp.
// Optional feature macro: RC_RESP_CLR_EN -- when defined, accepting a new
// command also drops resp_rdy so a stale acknowledge cannot satisfy it.
module remote_comm #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t       tx_state;
  logic [CW-1:0]   tx_baud;
  logic [3:0]      tx_bit;
  logic [8:0]      tx_shift;
  logic [7:0]      cmd_lo;

  rx_state_t       rx_state;
  logic [CW-1:0]   rx_baud;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;

  logic cmd_accept;
  logic tx_bit_done;
  logic tx_frame_done;
  logic tx_load_low;
  logic tx_shift_en;
  logic rx_bit_done;
  logic rx_start_edge;
  logic resp_clr;

  assign cmd_accept    = (tx_state == TX_IDLE) && snd_cmd;
  assign tx_bit_done   = (tx_baud == BIT_END);
  assign tx_frame_done = tx_bit_done && (tx_bit == 4'd9);
  assign tx_load_low   = (tx_state == TX_HIGH) && tx_frame_done;
  assign tx_shift_en   = (tx_state != TX_IDLE) && tx_bit_done && !tx_frame_done;

  assign rx_bit_done   = (rx_baud == BIT_END);
  assign rx_start_edge = (rx_state == RX_IDLE) && rx_prev && !rx_sync;

`ifdef RC_RESP_CLR_EN
  assign resp_clr = rx_start_edge || cmd_accept;
`else
  assign resp_clr = rx_start_edge;
`endif

  // Transmit byte staging: high byte goes straight into the shifter, low byte waits in cmd_lo.
  always_ff @(posedge clk) begin
    if (cmd_accept) begin
      tx_shift <= {1'b1, cmd[15:8]};
      cmd_lo   <= cmd[7:0];
    end else if (tx_load_low) begin
      tx_shift <= {1'b1, cmd_lo};
    end else if (tx_shift_en) begin
      tx_shift <= {1'b1, tx_shift[8:1]};
    end
  end

  // Command sequencer: start bit is driven directly, data/stop bits come from the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      TX       <= 1'b1;
      cmd_snt  <= 1'b0;
      tx_baud  <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (snd_cmd) begin
            cmd_snt  <= 1'b0;
            TX       <= 1'b0;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_state <= TX_HIGH;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (tx_bit_done) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit <= '0;
              if (tx_state == TX_HIGH) begin
                // Low byte start bit follows the high byte stop bit with no gap.
                TX       <= 1'b0;
                tx_state <= TX_LOW;
              end else begin
                TX       <= 1'b1;
                cmd_snt  <= 1'b1;
                tx_state <= TX_IDLE;
              end
            end else begin
              TX     <= tx_shift[0];
              tx_bit <= tx_bit + 4'd1;
            end
          end else begin
            tx_baud <= tx_baud + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receive shifter: LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if ((rx_state == RX_DATA) && rx_bit_done) begin
      rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  // Receiver: synchronize RX, detect start edge, sample each bit at its midpoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (resp_clr) begin
        resp_rdy <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_start_edge) begin
            rx_baud  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_baud == HALF_END) begin
            rx_baud <= '0;
            // A start bit that is high at its midpoint was a glitch.
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_baud <= rx_baud + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_bit_done) begin
            rx_baud <= '0;
            rx_bit  <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            rx_baud <= rx_baud + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_bit_done) begin
            // Byte is delivered whatever the stop bit level turned out to be.
            rx_baud  <= '0;
            resp     <= rx_shift;
            resp_rdy <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            rx_baud <= rx_baud + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: stimulus pushes expected TX frames and
// expected received bytes into queues; independent monitors decode the TX
// line and watch resp_rdy, popping and comparing as the DUT produces output.
module tb_remote_comm;

  localparam int B = 434;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit tx_mon_en = 1'b1;

  typedef struct { logic [7:0] b; int start; } tx_exp_t;
  typedef struct { logic [7:0] b; int lo; int hi; } rx_exp_t;

  tx_exp_t txq[$];
  rx_exp_t rxq[$];

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_win(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d, expected none", name, val);
  endtask

  task automatic issue_cmd(input logic [15:0] c, output int p);
    @(posedge clk); #1;
    cmd     = c;
    snd_cmd = 1'b1;
    p       = cyc;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
  endtask

  // Expected resp_rdy rise: stop-bit midpoint plus up to 4 clocks of synchronizer delay.
  task automatic drive_rx(input logic [7:0] b, input logic stop);
    rx_exp_t e;
    @(posedge clk); #1;
    RX   = 1'b0;
    e.b  = b;
    e.lo = cyc + 9 * B + B / 2;
    e.hi = e.lo + 4;
    rxq.push_back(e);
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(posedge clk); #1;
      RX = b[i];
    end
    repeat (B) @(posedge clk); #1;
    RX = stop;
    repeat (B) @(posedge clk); #1;
    RX = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  // TX line monitor: decode 8N1 frames at bit midpoints and compare with the queue.
  initial begin : tx_mon
    int s;
    logic [7:0] got;
    tx_exp_t e;
    got = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_mon_en && rst_n === 1'b1 && TX === 1'b0) begin
        s = cyc;
        repeat (B / 2) @(negedge clk);
        check("tx_start_bit", TX, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          got[i] = TX;
        end
        repeat (B) @(negedge clk);
        check("tx_stop_bit", TX, 1);
        if (txq.size() == 0) begin
          fail_now("tx_unexpected_frame", s);
        end else begin
          e = txq.pop_front();
          check("tx_byte", got, e.b);
          check("tx_frame_start", s, e.start);
        end
      end
    end
  end

  // Response monitor: every rising resp_rdy must match the next expected byte.
  initial begin : rx_mon
    logic prev;
    rx_exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_rdy === 1'b1 && prev !== 1'b1) begin
        if (rxq.size() == 0) begin
          fail_now("rx_unexpected_resp", cyc);
        end else begin
          e = rxq.pop_front();
          check("rx_resp", resp, e.b);
          check_win("rx_rdy_time", cyc, e.lo, e.hi);
        end
      end
      prev = resp_rdy;
    end
  end

  initial begin : watchdog
    wait (cyc >= 80000);
    $display("FAIL watchdog: reached cycle %0d without finishing", cyc);
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int p;
    int p2;
    int bad;
    logic exp_rdy;
    tx_exp_t te;

    rst_n   = 1'b0;
    RX      = 1'b1;
    cmd     = 16'h0000;
    snd_cmd = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Reset state after a long idle
    repeat (1000) @(negedge clk);
    check("reset_tx", TX, 1);
    check("reset_cmd_snt", cmd_snt, 0);
    check("reset_resp_rdy", resp_rdy, 0);
    check("reset_resp", resp, 8'h00);

    // Command 0x4BF1, concurrent RX of 0xA5, ignored second command during low byte
    issue_cmd(16'h4BF1, p);
    te.b = 8'h4B; te.start = p + 1;         txq.push_back(te);
    te.b = 8'hF1; te.start = p + 1 + 10 * B; txq.push_back(te);
    fork
      begin
        while (cmd_snt !== 1'b1 && cyc < p + 9000) @(negedge clk);
        check("cmd_snt_latency", cyc - p, 8681);
      end
      begin
        repeat (2000) @(posedge clk);
        drive_rx(8'hA5, 1'b1);
      end
      begin
        repeat (10 * B + 1000) @(posedge clk);
        issue_cmd(16'h2002, p2);
      end
    join
    repeat (12 * B) @(negedge clk);
    check("cmd_snt_hold", cmd_snt, 1);
    check("tx_queue_drained", txq.size(), 0);

    // resp_rdy holds until the next start edge; resp holds until the frame completes
    @(negedge clk);
    check("rdy_before_edge", resp_rdy, 1);
    check("resp_hold_a5", resp, 8'hA5);
    fork
      drive_rx(8'h3C, 1'b1);
      begin
        @(negedge RX);
        repeat (5) @(negedge clk);
        check("rdy_cleared_by_start", resp_rdy, 0);
        check("resp_hold_during_rx", resp, 8'hA5);
      end
    join

    // Start-bit glitch is rejected; then a good frame and a frame with a low stop bit
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (40) @(posedge clk); #1;
    RX = 1'b1;
    repeat (B) @(posedge clk);
    drive_rx(8'h5A, 1'b1);
    drive_rx(8'hC3, 1'b0);
    repeat (100) @(negedge clk);

    // Accepted command vs stale resp_rdy, then reset in data bit 5 of the high byte
`ifdef RC_RESP_CLR_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    tx_mon_en = 1'b0;
    issue_cmd(16'h1234, p);
    @(negedge clk);
    check("rdy_after_accept", resp_rdy, exp_rdy);
    check("cmd_snt_cleared", cmd_snt, 0);
    while (cyc < p + 1 + 6 * B + B / 2) @(negedge clk);
    check("tx_hi_bit5", TX, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx", TX, 1);
    check("midreset_cmd_snt", cmd_snt, 0);
    check("midreset_resp_rdy", resp_rdy, 0);
    check("midreset_resp", resp, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (3 * B) begin
      @(negedge clk);
      if (TX !== 1'b1 || cmd_snt !== 1'b0) bad++;
    end
    check("no_frame_after_reset", bad, 0);

    repeat (10) @(negedge clk);
    check("rx_queue_drained", rxq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
